// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- instruction-fetch stage.
//
// Owns the PC and the instruction-memory request handshake and produces the
// instruction / next-PC pair plus write and flush controls for the IF/ID
// pipeline register.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   stall_i                 hazard stall: hold the fetched word, PC does not advance
//   branch_i/branchTarget_i taken branch resolved in ID (wins over jump)
//   jump_i/jumpTarget_i     jump resolved in ID
//   imemReq_o/imemAddr_o    memory request valid / fetch address (= PC)
//   imemAck_i/imemData_i    memory response (may arrive in the request cycle)
//   inst_o/nextPC_o         instruction and its address + 4 towards IF/ID
//   IFID_o                  IF/ID write enable
//   IFFlush_o               IF/ID flush (asserted in the redirect cycle)
//   memStall_o              waiting on memory with no valid instruction
//
// Optional: define IFETCH_PERF_EN to add saturating counters fetchCnt_o
// (instructions delivered) and stallCnt_o (memory-wait or hold cycles).
module if_fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [31:0]        NOP_INST = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branchTarget_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jumpTarget_i,
  output logic              imemReq_o,
  output logic [ADDR_W-1:0] imemAddr_o,
  input  logic              imemAck_i,
  input  logic [31:0]       imemData_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] nextPC_o,
  output logic              IFID_o,
  output logic              IFFlush_o,
  output logic              memStall_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       fetchCnt_o,
  output logic [31:0]       stallCnt_o
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              redir_pend;  // one idle cycle after abandoning an unacked request
  logic [31:0]       hold_buf;

  logic              redirect;
  logic              req_live;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  always_comb begin
    pc_inc      = pc + ADDR_W'(4);
    target      = branch_i ? branchTarget_i : jumpTarget_i;
    target[1:0] = 2'b00;
    redirect    = !rst_i && (state != S_BOOT) && (branch_i || jump_i);
    req_live    = (state == S_REQ) && !redir_pend;
  end

  // Outputs are decoded from registered state; the ack path is a
  // combinational pass-through so zero-wait memory sustains 1 inst/cycle.
  always_comb begin
    imemAddr_o = pc;
    imemReq_o  = 1'b0;
    inst_o     = NOP_INST;
    nextPC_o   = pc_inc;
    IFID_o     = 1'b0;
    IFFlush_o  = 1'b0;
    memStall_o = 1'b0;
    if (rst_i) begin
      nextPC_o = RESET_PC + ADDR_W'(4);
    end else begin
      IFFlush_o = redirect;
      case (state)
        S_REQ: begin
          if (!redir_pend) begin
            imemReq_o  = 1'b1;
            memStall_o = !imemAck_i;
            if (imemAck_i) inst_o = imemData_i;
            IFID_o     = imemAck_i && !stall_i && !redirect;
          end
        end
        S_HOLD: begin
          inst_o = hold_buf;
          IFID_o = !stall_i && !redirect;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc         <= RESET_PC;
      state      <= S_BOOT;
      redir_pend <= 1'b0;
      hold_buf   <= NOP_INST;
    end else if (redirect) begin
      pc         <= target;
      state      <= S_REQ;
      // An unacked request is dropped for one cycle so a late response to the
      // old address cannot be mistaken for the new one.
      redir_pend <= req_live && !imemAck_i;
      hold_buf   <= NOP_INST;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (redir_pend) begin
            redir_pend <= 1'b0;
          end else if (imemAck_i) begin
            if (stall_i) begin
              hold_buf <= imemData_i;
              state    <= S_HOLD;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            pc    <= pc_inc;
            state <= S_REQ;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetchCnt_o <= '0;
      stallCnt_o <= '0;
    end else begin
      if (IFID_o && (fetchCnt_o != '1))
        fetchCnt_o <= fetchCnt_o + 32'd1;
      if ((memStall_o || (state == S_HOLD)) && (stallCnt_o != '1))
        stallCnt_o <= stallCnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit. A behavioural memory with
// programmable ack latency answers requests; delivered instructions are
// compared against a queue of expected {inst, nextPC} pairs.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, branch = 1'b0, jump = 1'b0;
  logic [31:0] btgt = '0, jtgt = '0;
  logic        imemReq, imemAck, IFID, IFFlush, memStall;
  logic [31:0] imemAddr, imemData, inst, nextPC;
  logic [3:0]  ctl;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetchCnt, stallCnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  int          cnt = 0;
  logic        mem_en = 1'b1;
  logic        force_ack = 1'b0;
  logic [63:0] sb[$];

  assign ctl = {imemReq, IFID, IFFlush, memStall};

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_i(branch), .branchTarget_i(btgt),
    .jump_i(jump), .jumpTarget_i(jtgt),
    .imemReq_o(imemReq), .imemAddr_o(imemAddr),
    .imemAck_i(imemAck), .imemData_i(imemData),
    .inst_o(inst), .nextPC_o(nextPC),
    .IFID_o(IFID), .IFFlush_o(IFFlush), .memStall_o(memStall)
`ifdef IFETCH_PERF_EN
    , .fetchCnt_o(fetchCnt), .stallCnt_o(stallCnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h8C22_0004;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory: acks once the request has been held for 'lat' cycles;
  // force_ack injects a stray response carrying junk data.
  assign imemData = force_ack ? 32'hDEAD_BEEF : mem_word(imemAddr);
  assign imemAck  = mem_en && ((imemReq && (cnt >= lat)) || force_ack);
  always @(posedge clk) begin
    if (!imemReq || imemAck) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    sb.push_back({mem_word(a), a + 32'd4});
  endtask

  // Waits to mid-cycle and scores any delivery against the queue.
  task automatic settle();
    logic [63:0] e;
    @(negedge clk);
    checks++;
    if (IFID && IFFlush) begin errors++; $display("FAIL ifid_flush_excl IFID=%b IFFlush=%b exp not both 1", IFID, IFFlush); end
    if (IFID) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL sb_unexpected inst=%h nextPC=%h exp no delivery", inst, nextPC);
      end else begin
        e = sb.pop_front();
        if ({inst, nextPC} !== e) begin errors++; $display("FAIL sb_delivery inst=%h nextPC=%h exp inst=%h nextPC=%h", inst, nextPC, e[63:32], e[31:0]); end
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    force_ack = 1'b0; mem_en = 1'b1; lat = 0;
    adv(); adv();
    rst = 1'b0;
    sb.delete();
    settle();
    checks++; if (ctl !== 4'b0000 || imemAddr !== 32'h0) begin errors++; $display("FAIL boot_cycle ctl=%b addr=%h exp ctl=0000 addr=0", ctl, imemAddr); end
    adv();
  endtask

  task automatic test_reset();
    rst = 1'b1; branch = 1'b1; btgt = 32'h40; force_ack = 1'b1; mem_en = 1'b1;
    adv(); adv();
    settle();
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL reset_ctl ctl=%b exp 0000", ctl); end
    checks++; if (inst !== 32'h0 || nextPC !== 32'h4) begin errors++; $display("FAIL reset_data inst=%h nextPC=%h exp 0/4", inst, nextPC); end
    checks++; if (imemAddr !== 32'h0) begin errors++; $display("FAIL reset_pc addr=%h exp 0", imemAddr); end
    adv();
    rst = 1'b0; force_ack = 1'b0;
    settle();   // branch held during S_BOOT must be ignored
    checks++; if (ctl !== 4'b0000 || nextPC !== 32'h4) begin errors++; $display("FAIL boot_ignore_branch ctl=%b nextPC=%h exp 0000/4", ctl, nextPC); end
    adv();
    branch = 1'b0; mem_en = 1'b0;
    settle();
    checks++; if (imemAddr !== 32'h0 || ctl !== 4'b1001) begin errors++; $display("FAIL first_req addr=%h ctl=%b exp 0/1001", imemAddr, ctl); end
    adv();
  endtask

  task automatic test_zero_wait();
    apply_reset();
    for (int i = 0; i < 4; i++) push(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++; if (imemAddr !== 32'(i * 4) || ctl !== 4'b1100) begin errors++; $display("FAIL zw_seq%0d addr=%h ctl=%b exp %h/1100", i, imemAddr, ctl, 32'(i * 4)); end
      adv();
    end
    mem_en = 1'b0;
    settle();
    checks++; if (imemAddr !== 32'h10 || ctl !== 4'b1001) begin errors++; $display("FAIL zw_end addr=%h ctl=%b exp 10/1001", imemAddr, ctl); end
    adv();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL zw_leftover left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_wait2();
    apply_reset();
    lat = 2;
    for (int k = 0; k < 3; k++) begin
      push(32'(k * 4));
      for (int c = 0; c < 3; c++) begin
        settle();
        checks++;
        if (imemAddr !== 32'(k * 4) || ctl !== ((c < 2) ? 4'b1001 : 4'b1100)) begin
          errors++; $display("FAIL w2_k%0d_c%0d addr=%h ctl=%b exp %h/%b", k, c, imemAddr, ctl, 32'(k * 4), (c < 2) ? 4'b1001 : 4'b1100);
        end
        adv();
      end
    end
    mem_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL w2_leftover left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_stall();
    apply_reset();
    push(32'h0); push(32'h4); push(32'h8);
    settle(); adv();
    settle(); adv();
    stall = 1'b1;
    settle();
    checks++; if (ctl !== 4'b1000 || inst !== 32'h8C22_0004 || imemAddr !== 32'h8) begin errors++; $display("FAIL st_capture ctl=%b inst=%h addr=%h exp 1000/8c220004/8", ctl, inst, imemAddr); end
    adv();
    for (int h = 0; h < 2; h++) begin
      settle();
      checks++; if (ctl !== 4'b0000 || inst !== 32'h8C22_0004 || imemAddr !== 32'h8) begin errors++; $display("FAIL st_hold%0d ctl=%b inst=%h addr=%h exp 0000/8c220004/8", h, ctl, inst, imemAddr); end
      adv();
    end
    stall = 1'b0;
    settle();
    checks++; if (ctl !== 4'b0100 || imemAddr !== 32'h8) begin errors++; $display("FAIL st_release ctl=%b addr=%h exp 0100/8", ctl, imemAddr); end
    adv();
    mem_en = 1'b0;
    settle();
    checks++; if (imemAddr !== 32'hC || ctl !== 4'b1001) begin errors++; $display("FAIL st_next addr=%h ctl=%b exp c/1001", imemAddr, ctl); end
    adv();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL st_leftover left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_branch_late();
    apply_reset();
    for (int i = 0; i < 4; i++) push(32'(i * 4));
    for (int i = 0; i < 4; i++) begin settle(); adv(); end
    lat = 2;
    settle();
    checks++; if (imemAddr !== 32'h10 || ctl !== 4'b1001) begin errors++; $display("FAIL bl_wait addr=%h ctl=%b exp 10/1001", imemAddr, ctl); end
    adv();
    branch = 1'b1; btgt = 32'h40;
    settle();
    checks++; if (ctl !== 4'b1011) begin errors++; $display("FAIL bl_flush ctl=%b exp 1011", ctl); end
    adv();
    branch = 1'b0; force_ack = 1'b1; lat = 0;
    settle();
    checks++; if (ctl !== 4'b0000 || imemAddr !== 32'h40) begin errors++; $display("FAIL bl_drop ctl=%b addr=%h exp 0000/40", ctl, imemAddr); end
    adv();
    force_ack = 1'b0;
    push(32'h40);
    settle();
    checks++; if (ctl !== 4'b1100 || imemAddr !== 32'h40) begin errors++; $display("FAIL bl_target ctl=%b addr=%h exp 1100/40", ctl, imemAddr); end
    adv();
    mem_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bl_leftover left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    push(32'h0);
    settle(); adv();
    jump = 1'b1; jtgt = 32'h103;
    settle();
    checks++; if (ctl !== 4'b1010) begin errors++; $display("FAIL ra_discard ctl=%b exp 1010", ctl); end
    adv();
    jump = 1'b0;
    push(32'h100);
    settle();
    checks++; if (imemAddr !== 32'h100 || ctl !== 4'b1100) begin errors++; $display("FAIL ra_aligned addr=%h ctl=%b exp 100/1100", imemAddr, ctl); end
    adv();
    mem_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ra_leftover left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_branch_jump_stall();
    apply_reset();
    stall = 1'b1;
    settle();
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL bj_capture ctl=%b exp 1000", ctl); end
    adv();
    branch = 1'b1; btgt = 32'h80; jump = 1'b1; jtgt = 32'h100;
    settle();
    checks++; if (ctl !== 4'b0010) begin errors++; $display("FAIL bj_flush ctl=%b exp 0010", ctl); end
    adv();
    branch = 1'b0; jump = 1'b0;
    settle();
    checks++; if (imemAddr !== 32'h80 || ctl !== 4'b1000) begin errors++; $display("FAIL bj_pc addr=%h ctl=%b exp 80/1000", imemAddr, ctl); end
    adv();
    push(32'h80);
    stall = 1'b0; mem_en = 1'b0;
    settle();
    checks++; if (ctl !== 4'b0100) begin errors++; $display("FAIL bj_release ctl=%b exp 0100", ctl); end
    adv();
    settle();
    checks++; if (imemAddr !== 32'h84 || ctl !== 4'b1001) begin errors++; $display("FAIL bj_next addr=%h ctl=%b exp 84/1001", imemAddr, ctl); end
    adv();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bj_leftover left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    jump = 1'b1; jtgt = 32'hFFFF_FFFC;
    settle(); adv();
    jump = 1'b0;
    push(32'hFFFF_FFFC); push(32'h0);
    settle();
    checks++; if (imemAddr !== 32'hFFFF_FFFC || nextPC !== 32'h0) begin errors++; $display("FAIL wr_top addr=%h nextPC=%h exp fffffffc/0", imemAddr, nextPC); end
    adv();
    settle();
    checks++; if (imemAddr !== 32'h0 || ctl !== 4'b1100) begin errors++; $display("FAIL wr_wrap addr=%h ctl=%b exp 0/1100", imemAddr, ctl); end
    adv();
    lat = 5;
    settle();
    checks++; if (imemAddr !== 32'h4 || ctl !== 4'b1001) begin errors++; $display("FAIL wr_wait addr=%h ctl=%b exp 4/1001", imemAddr, ctl); end
    adv();
    rst = 1'b1; force_ack = 1'b1;
    settle();
    checks++; if (ctl !== 4'b0000 || inst !== 32'h0 || nextPC !== 32'h4) begin errors++; $display("FAIL wr_rst_out ctl=%b inst=%h nextPC=%h exp 0000/0/4", ctl, inst, nextPC); end
    adv();
    rst = 1'b0; force_ack = 1'b0;
    settle();
    checks++; if (imemAddr !== 32'h0 || ctl !== 4'b0000) begin errors++; $display("FAIL wr_rst_pc addr=%h ctl=%b exp 0/0000", imemAddr, ctl); end
    adv();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wr_leftover left=%0d exp 0", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait2();
    test_stall();
    test_branch_late();
    test_redirect_ack();
    test_branch_jump_stall();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and the instruction-memory request handshake.
- Produces the instruction/next-PC pair and the write/flush controls consumed by the IF/ID pipeline register.
- Accepts stall from the hazard unit and branch/jump redirects resolved in ID.
- Sits between instruction memory and IF/ID; drives IF/ID inst_i, nextPC_i, IFID_i and IFFlush_i.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, instruction word presented when no valid fetch.
ADDR_W, 32, PC/address width (fixed 32 in this design; bits [1:0] always 0).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active high.
stall_i  in  1  hazard stall; hold current fetch result, do not advance PC.
branch_i  in  1  taken branch resolved in ID (1-cycle pulse).
branchTarget_i  in  32  branch target address.
jump_i  in  1  jump resolved in ID (1-cycle pulse).
jumpTarget_i  in  32  jump target address.
imemReq_o  out  1  instruction-memory request valid.
imemAddr_o  out  32  fetch address (= PC register).
imemAck_i  in  1  memory returns data this cycle; may be same cycle as request.
imemData_i  in  32  instruction word, valid when imemAck_i=1.
inst_o  out  32  fetched instruction to IF/ID.
nextPC_o  out  32  address of inst_o + 4.
IFID_o  out  1  IF/ID write enable; 1 = inst_o/nextPC_o valid this cycle.
IFFlush_o  out  1  IF/ID flush; inst in IF/ID becomes NOP.
memStall_o  out  1  high while waiting on memory with no valid instruction.

Behaviour:
- Reset (rst_i=1 at posedge): pc=RESET_PC, state=S_BOOT, redirect pending cleared, hold buffer cleared. Outputs while in reset/S_BOOT: imemReq_o=0, inst_o=NOP_INST, nextPC_o=RESET_PC+4, IFID_o=0, IFFlush_o=0, memStall_o=0. Reset mid-transaction discards any outstanding request; a late imemAck_i is ignored.
- States:
  - S_BOOT: one cycle, then S_REQ.
  - S_REQ: imemReq_o=1, imemAddr_o=pc held stable until ack.
  - S_HOLD: instruction captured, stall_i active.
- S_REQ, imemAck_i=1, stall_i=0, no redirect: inst_o=imemData_i, nextPC_o=pc+4, IFID_o=1 (combinational pass-through). pc<=pc+4 at edge. Remain S_REQ, giving 1 instruction/cycle with zero-wait memory.
- S_REQ, imemAck_i=0: memStall_o=1, IFID_o=0, inst_o=NOP_INST, pc held.
- S_REQ, ack with stall_i=1: capture imemData_i into hold buffer, go to S_HOLD, pc unchanged.
- S_HOLD: imemReq_o=0, inst_o=buffer, IFID_o=0. When stall_i=0: IFID_o=1 that cycle, pc<=pc+4, go to S_REQ.
- Redirect (branch_i or jump_i) in any state but S_BOOT:
  - pc<=target at edge; IFFlush_o=1 the same cycle.
  - Hold buffer invalidated; next state S_REQ.
  - Outstanding request with no ack this cycle: request drops next cycle and the new address is issued. An ack arriving in the redirect cycle is discarded (IFID_o=0).
  - branch_i and jump_i together: branch_i wins.
  - Redirect overrides stall_i.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. Targets forced word-aligned (bits [1:0] cleared).
- IFFlush_o and IFID_o never both 1.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined: adds outputs fetchCnt_o[31:0] (instructions delivered with IFID_o=1) and stallCnt_o[31:0] (cycles with memStall_o=1 or state S_HOLD). Both clear on rst_i and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then zero-wait memory (ack = req) -> imemAddr_o sequence 0,4,8,12 on consecutive cycles; IFID_o=1 from the 2nd cycle after reset; nextPC_o=4,8,12,16.
- Memory with 2-cycle ack latency -> memStall_o=1 for 2 cycles per fetch, address stable, IFID_o pulses once per instruction.
- stall_i=1 for 3 cycles on ack of inst 32'h8C220004 at PC 8 -> inst_o holds 32'h8C220004, pc stays 8, IFID_o=0; after release IFID_o=1 once, next address 12.
- branch_i with target 32'h40 while fetch of PC 16 is outstanding -> IFFlush_o=1 one cycle, late data discarded, next imemAddr_o=32'h40.
- branch_i (target 32'h80) with jump_i (target 32'h100) in the same cycle, plus stall_i=1 -> pc=32'h80, IFFlush_o=1.
- PC at 32'hFFFF_FFFC with zero-wait memory -> next fetch address 0; rst_i asserted mid-wait -> pc=RESET_PC, outputs at reset values.
